mem_arbiter: RTL and testbench

Three-port round-robin arbiter that shares the single synchronous memory inside `top` (ADDR_WIDTH-bit address, DATA_WIDTH-bit data) among the CPU, the PS/2 keyboard buffer writer and the VGA display scanner. It sits between these requesters and the memory instance. It serialises their accesses with a request/acknowledge handshake and drives the memory's write-enable, address and write-data inputs.

---
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Three-port round-robin arbiter in front of a single synchronous memory.
// Each access takes IDLE -> ACCESS -> RESP; the winner's request is latched at grant.
//
// state  | meaning
// IDLE   | waiting for a request; picks the next winner round-robin
// ACCESS | memory driven with the latched address/data/write flag
// RESP   | registered read data available; ack pulses to the granted port
module mem_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2:0]              req,
  input  logic [2:0]              we,
  input  logic [3*ADDR_WIDTH-1:0] addr,
  input  logic [3*DATA_WIDTH-1:0] wdata,
  output logic [2:0]              ack,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [1:0]              grant,
  output logic                    busy,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_data,
  input  logic [DATA_WIDTH-1:0]   mem_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state, state_nxt;
  logic [1:0]              last;
  logic [1:0]              grant_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [1:0]              winner;
  logic                    take;
  logic [ADDR_WIDTH-1:0]   addr_a  [3];
  logic [DATA_WIDTH-1:0]   wdata_a [3];

  for (genvar i = 0; i < 3; i++) begin : g_unpack
    assign addr_a[i]  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[i] = wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search order starts one past the last winner; idle ports are skipped for free.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] l);
    logic [1:0] c0, c1, c2;
    case (l)
      2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
      2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
      default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
    endcase
    if (r[c0])      return c0;
    else if (r[c1]) return c1;
    else            return c2;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 2'd2;
      grant_q <= 2'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        last    <= winner;
        grant_q <= winner;
        we_q    <= we[winner];
        addr_q  <= addr_a[winner];
        wdata_q <= wdata_a[winner];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    winner    = rr_pick(req, last);
    ack       = 3'b000;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        if (req != 3'b000) begin
          take      = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        mem_we    = we_q;
        state_nxt = RESP;
      end
      RESP: begin
        ack       = 3'b001 << grant_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign grant    = grant_q;
  assign busy     = (state != IDLE);
  assign mem_addr = addr_q;
  assign mem_data = wdata_q;
  assign rd_data  = mem_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_arbiter;
  localparam int AW = 6;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [2:0]      req = '0;
  logic [2:0]      we = '0;
  logic [3*AW-1:0] addr = '0;
  logic [3*DW-1:0] wdata = '0;
  logic [2:0]      ack;
  logic [DW-1:0]   rd_data;
  logic [1:0]      grant;
  logic            busy;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data;
  logic [DW-1:0]   mem_out = '0;

  int n_checks = 0;
  int n_fail = 0;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rd_data(rd_data), .grant(grant), .busy(busy),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // physical memory with registered read
  logic [DW-1:0] mem [64];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
    mem_out <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time, age counts cycles since grant.
  int            age = 0;
  int            m_last = 2;
  int            m_grant = 0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_mem [64];

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_ack", ack, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_grant", grant, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_data", mem_data, 0);
      age = 0; m_last = 2; m_grant = 0;
    end else begin
      chk("busy", busy, age != 0);
      chk("mem_we", mem_we, (age == 1) && m_we);
      chk("ack", ack, (age == 2) ? (32'd1 << m_grant) : 32'd0);
      chk("ack_onehot", $countones(ack) <= 1, 1);
      chk("grant", grant, m_grant);
      if (age == 1) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_data", mem_data, m_wdata);
      end
      if (age == 2 && !m_we) chk("rd_data", rd_data, m_mem[m_addr]);
      if (age == 0) begin
        if (req != 0) begin
          for (int k = 1; k <= 3; k++) begin
            int c;
            c = (m_last + k) % 3;
            if (req[c]) begin
              m_grant = c;
              break;
            end
          end
          m_last  = m_grant;
          m_we    = we[m_grant];
          m_addr  = addr[m_grant*AW +: AW];
          m_wdata = wdata[m_grant*DW +: DW];
          age = 1;
        end
      end else if (age == 1) begin
        if (m_we) m_mem[m_addr] = m_wdata;
        age = 2;
      end else begin
        age = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    step();
    step();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = '0;
      m_mem[i] = '0;
    end
    mem[5] = 16'h1234;
    m_mem[5] = 16'h1234;

    // reset state
    step();
    chk("reset_busy", busy, 0);
    chk("reset_grant", grant, 0);
    rst_n = 1'b1;
    step();

    // single read
    req = 3'b001; we = 3'b000; addr[0 +: AW] = 6'd5;
    step();
    chk("rd_mem_addr", mem_addr, 5);
    chk("rd_mem_we", mem_we, 0);
    step();
    chk("rd_ack", ack, 3'b001);
    chk("rd_data_1234", rd_data, 16'h1234);
    req = 3'b000;
    step();
    chk("rd_busy_done", busy, 0);

    // write then read
    req = 3'b010; we = 3'b010; addr[AW +: AW] = 6'h3F; wdata[DW +: DW] = 16'h00AB;
    step();
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 6'h3F);
    chk("wr_mem_data", mem_data, 16'h00AB);
    step();
    chk("wr_mem_we_off", mem_we, 0);
    chk("wr_ack", ack, 3'b010);
    req = 3'b000; we = 3'b000;
    step();
    req = 3'b100; addr[2*AW +: AW] = 6'h3F;
    step();
    step();
    chk("rd2_ack", ack, 3'b100);
    chk("rd2_data", rd_data, 16'h00AB);
    req = 3'b000;
    step();

    // full contention from reset release
    do_reset();
    req = 3'b111; we = 3'b000;
    addr = {6'd3, 6'd2, 6'd1};
    rst_n = 1'b1;
    step();
    step();
    chk("cont_ack0", ack, 3'b001);
    for (int k = 1; k < 6; k++) begin
      step(); step(); step();
      chk("cont_ack", ack, 3'b001 << (k % 3));
    end
    req = 3'b000;
    step(); step();

    // fairness with a gap
    do_reset();
    req = 3'b101;
    rst_n = 1'b1;
    step();
    step();
    chk("fair_ack0", ack, 3'b001);
    step(); step(); step();
    chk("fair_ack1", ack, 3'b100);
    step(); step(); step();
    chk("fair_ack2", ack, 3'b001);
    step(); step(); step();
    chk("fair_ack3", ack, 3'b100);
    req = 3'b000;
    step(); step();

    // reset mid-write
    req = 3'b001; we = 3'b001; addr[0 +: AW] = 6'd9; wdata[0 +: DW] = 16'hBEEF;
    step();
    chk("rmw_mem_we_pre", mem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rmw_mem_we_drop", mem_we, 0);
    chk("rmw_ack", ack, 0);
    chk("rmw_busy", busy, 0);
    req = 3'b111; we = 3'b000;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("rmw_first_grant", grant, 0);
    chk("rmw_mem9", mem[9], 0);
    req = 3'b000;
    step();
    chk("rmw_ack_after", ack, 3'b001);
    step();

    // request withdrawn after grant
    req = 3'b100; addr[2*AW +: AW] = 6'd5;
    step();
    req = 3'b000;
    step();
    chk("wd_ack", ack, 3'b100);
    chk("wd_rd_data", rd_data, 16'h1234);
    step();
    step();
    step();
    chk("wd_busy", busy, 0);
    chk("wd_no_ack", ack, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
